mac_rr_scheduler: RTL and testbench

- Shares one external pipelined mac_unit among NUM_REQ requesters, e.g. parallel conv1d window/channel engines.
- Arbitrates round-robin and drives the MAC operand, accumulator-in and enable ports.
- Tracks each in-flight operation with an ID tag pipeline and returns each result to its requester.
- Supports a drain/quiesce sequence so the system controller can stop issue and wait for an empty pipeline.

---
 rtl/mac_pkg.sv | 24 ++
 rtl/mac_rr_scheduler_rr_arbiter.sv | 45 ++++
 rtl/mac_rr_scheduler.sv | 166 ++++++++++++++++
 tb/tb_mac_rr_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants, FSM state encoding and width helper for the MAC scheduler.
package mac_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_ACCUM_WIDTH = 24;
  localparam int DEF_MAC_LATENCY = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } state_t;

  // Never returns less than 1 so that single-entry fields still get a bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/mac_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: rotating-priority search from rr_ptr, which advances past each winner.
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic                i_block,
  output logic [NUM_REQ-1:0]  o_gnt,
  output logic [ID_WIDTH-1:0] o_id,
  output logic                o_valid
);

  logic [ID_WIDTH-1:0] r_rr_ptr;
  logic [ID_WIDTH-1:0] w_idx;
  logic                w_found;

  always_comb begin
    o_gnt   = '0;
    o_id    = '0;
    w_idx   = '0;
    w_found = 1'b0;
    if (!i_block) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_idx = ID_WIDTH'((int'(r_rr_ptr) + k) % NUM_REQ);
        if (!w_found && i_req[w_idx]) begin
          w_found      = 1'b1;
          o_gnt[w_idx] = 1'b1;
          o_id         = w_idx;
        end
      end
    end
    o_valid = w_found;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (o_valid) begin
      r_rr_ptr <= (o_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : o_id + ID_WIDTH'(1);
    end
  end

endmodule

// File: rtl/mac_rr_scheduler.sv
// Shares one pipelined MAC among NUM_REQ requesters with ID-tagged result return and drain.
// Optional counters perf_grants/perf_stalls are built when MAC_RR_SCHEDULER_PERF_EN is defined.
module mac_rr_scheduler
  import mac_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ACCUM_WIDTH = DEF_ACCUM_WIDTH,
  parameter int MAC_LATENCY = DEF_MAC_LATENCY,
  parameter int ID_WIDTH    = clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b,
  input  logic [NUM_REQ*ACCUM_WIDTH-1:0] req_cin,
  output logic [NUM_REQ-1:0]             gnt,
  input  logic                           drain,
  output logic                           mac_en,
  output logic [DATA_WIDTH-1:0]          mac_a,
  output logic [DATA_WIDTH-1:0]          mac_b,
  output logic [ACCUM_WIDTH-1:0]         mac_cin,
  input  logic [ACCUM_WIDTH-1:0]         mac_cout,
  output logic                           rsp_valid,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic [ACCUM_WIDTH-1:0]         rsp_data,
  output logic                           idle,
  output logic                           drain_done
`ifdef MAC_RR_SCHEDULER_PERF_EN
  ,
  output logic [15:0]                    perf_grants,
  output logic [15:0]                    perf_stalls
`endif
);

  localparam int CNT_W = clog2(MAC_LATENCY + 1);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_inflight;
  logic [CNT_W-1:0]       w_inflight_nxt;
  logic [MAC_LATENCY-1:0] r_tag_vld;
  logic [ID_WIDTH-1:0]    r_tag_id [MAC_LATENCY];
  logic                   r_drain_q;
  logic                   r_drain_done;
  logic                   w_block;
  logic                   w_grant;
  logic [ID_WIDTH-1:0]    w_gnt_id;

  assign w_block = drain | (r_state == ST_DRAIN);

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (req),
    .i_block (w_block),
    .o_gnt   (gnt),
    .o_id    (w_gnt_id),
    .o_valid (w_grant)
  );

  always_comb begin
    mac_a   = '0;
    mac_b   = '0;
    mac_cin = '0;
    if (w_grant) begin
      mac_a   = req_a[int'(w_gnt_id)*DATA_WIDTH +: DATA_WIDTH];
      mac_b   = req_b[int'(w_gnt_id)*DATA_WIDTH +: DATA_WIDTH];
      mac_cin = req_cin[int'(w_gnt_id)*ACCUM_WIDTH +: ACCUM_WIDTH];
    end
  end

  // Bubbles must keep the MAC advancing so earlier results still emerge on time.
  assign mac_en = w_grant | (|r_tag_vld);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_vld <= '0;
      for (int i = 0; i < MAC_LATENCY; i++) r_tag_id[i] <= '0;
    end else if (mac_en) begin
      r_tag_vld[0] <= w_grant;
      r_tag_id[0]  <= w_gnt_id;
      for (int i = 1; i < MAC_LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
    end
  end

  assign rsp_valid  = r_tag_vld[MAC_LATENCY-1];
  assign rsp_id     = r_tag_id[MAC_LATENCY-1];
  assign rsp_data   = rsp_valid ? mac_cout : '0;
  assign idle       = (r_state == ST_IDLE) && (r_inflight == '0);
  assign drain_done = r_drain_done;

  always_comb begin
    w_inflight_nxt = r_inflight;
    if (w_grant && !rsp_valid)      w_inflight_nxt = r_inflight + CNT_W'(1);
    else if (!w_grant && rsp_valid) w_inflight_nxt = r_inflight - CNT_W'(1);
  end

  // A drain request on an already-empty pipeline acknowledges only on drain's rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_inflight   <= '0;
      r_drain_q    <= 1'b0;
      r_drain_done <= 1'b0;
    end else begin
      r_inflight   <= w_inflight_nxt;
      r_drain_q    <= drain;
      r_drain_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (drain) begin
            if (w_inflight_nxt != '0) r_state <= ST_DRAIN;
            else if (!r_drain_q)      r_drain_done <= 1'b1;
          end else if (w_grant) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (drain) begin
            if (w_inflight_nxt != '0) begin
              r_state <= ST_DRAIN;
            end else begin
              r_state      <= ST_IDLE;
              r_drain_done <= 1'b1;
            end
          end else if (!w_grant && (w_inflight_nxt == '0)) begin
            r_state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (w_inflight_nxt == '0) begin
            r_state      <= ST_IDLE;
            r_drain_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef MAC_RR_SCHEDULER_PERF_EN
  logic [15:0] r_perf_grants;
  logic [15:0] r_perf_stalls;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_grants <= '0;
      r_perf_stalls <= '0;
    end else begin
      if (w_grant && (r_perf_grants != 16'hFFFF)) r_perf_grants <= r_perf_grants + 16'd1;
      if ((|req) && !w_grant && (r_perf_stalls != 16'hFFFF)) r_perf_stalls <= r_perf_stalls + 16'd1;
    end
  end

  assign perf_grants = r_perf_grants;
  assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_mac_rr_scheduler.sv
// Directed bench for mac_rr_scheduler with a 3-stage behavioural MAC attached.
`timescale 1ns/1ps
module tb_mac_rr_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 24;
  localparam int L  = 3;
  localparam int IW = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N*AW-1:0] req_cin;
  logic [N-1:0]    gnt;
  logic            drain;
  logic            mac_en;
  logic [DW-1:0]   mac_a;
  logic [DW-1:0]   mac_b;
  logic [AW-1:0]   mac_cin;
  logic [AW-1:0]   mac_cout;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [AW-1:0]   rsp_data;
  logic            idle;
  logic            drain_done;
`ifdef MAC_RR_SCHEDULER_PERF_EN
  logic [15:0]     perf_grants;
  logic [15:0]     perf_stalls;
`endif

  mac_rr_scheduler #(
    .NUM_REQ     (N),
    .DATA_WIDTH  (DW),
    .ACCUM_WIDTH (AW),
    .MAC_LATENCY (L),
    .ID_WIDTH    (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .gnt        (gnt),
    .drain      (drain),
    .mac_en     (mac_en),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_cin    (mac_cin),
    .mac_cout   (mac_cout),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .idle       (idle),
    .drain_done (drain_done)
`ifdef MAC_RR_SCHEDULER_PERF_EN
    ,
    .perf_grants (perf_grants),
    .perf_stalls (perf_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External MAC: a*b+cin, result valid L enabled cycles after presentation.
  logic signed [AW-1:0] m_a_ext;
  logic signed [AW-1:0] m_b_ext;
  logic [AW-1:0]        m_pipe [L];

  assign m_a_ext  = {{(AW-DW){mac_a[DW-1]}}, mac_a};
  assign m_b_ext  = {{(AW-DW){mac_b[DW-1]}}, mac_b};
  assign mac_cout = m_pipe[L-1];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < L; i++) m_pipe[i] <= '0;
    end else if (mac_en) begin
      m_pipe[0] <= m_a_ext * m_b_ext + mac_cin;
      for (int i = 1; i < L; i++) m_pipe[i] <= m_pipe[i-1];
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_dd;
  int n_rsp;
  int exp_data [N] = '{2, 14, 26, 38};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input int a, input int b, input int cin);
    req_a[i*DW +: DW]   = DW'(a);
    req_b[i*DW +: DW]   = DW'(b);
    req_cin[i*AW +: AW] = AW'(cin);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req   = '0;
    drain = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    req     = '0;
    drain   = 1'b0;
    req_a   = '0;
    req_b   = '0;
    req_cin = '0;
    @(negedge clk);
    #1;
    check_val("rst_gnt", gnt, 0);
    check_val("rst_mac_en", mac_en, 0);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_drain_done", drain_done, 0);
    check_val("rst_idle", idle, 1);
    check_val("rst_mac_a", mac_a, 0);
    check_val("rst_mac_cin", mac_cin, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single op: 3*4+5 from requester 0.
    set_op(0, 3, 4, 5);
    @(negedge clk); req = 4'b0001; #1;
    check_val("t1_gnt", gnt, 4'b0001);
    check_val("t1_mac_a", mac_a, 3);
    check_val("t1_mac_b", mac_b, 4);
    check_val("t1_mac_cin", mac_cin, 5);
    check_val("t1_mac_en", mac_en, 1);
    @(negedge clk); req = '0; #1;
    check_val("t1_rsp_early1", rsp_valid, 0);
    check_val("t1_busy", idle, 0);
    check_val("t1_mac_a_quiet", mac_a, 0);
    @(negedge clk); #1;
    check_val("t1_rsp_early2", rsp_valid, 0);
    @(negedge clk); #1;
    check_val("t1_rsp_valid", rsp_valid, 1);
    check_val("t1_rsp_id", rsp_id, 0);
    check_val("t1_rsp_data", rsp_data, 17);
    @(negedge clk); #1;
    check_val("t1_rsp_gone", rsp_valid, 0);
    check_val("t1_idle", idle, 1);
    check_val("t1_mac_en_off", mac_en, 0);

    // All four requesting: full-rate round robin from rr_ptr=0.
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, i + 1, 2, 10 * i);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk); req = (k < 8) ? 4'b1111 : 4'b0000; #1;
      if (k < 8) check_val("t2_gnt", gnt, 4'b0001 << (k % 4));
      else       check_val("t2_gnt_none", gnt, 0);
      check_val("t2_mac_en", mac_en, 1);
      if (k >= 3) begin
        check_val("t2_rsp_valid", rsp_valid, 1);
        check_val("t2_rsp_id", rsp_id, (k - 3) % 4);
        check_val("t2_rsp_data", rsp_data, exp_data[(k - 3) % 4]);
      end else begin
        check_val("t2_rsp_early", rsp_valid, 0);
      end
    end
    @(negedge clk); #1;
    check_val("t2_mac_en_off", mac_en, 0);
    check_val("t2_idle", idle, 1);

    // Move rr_ptr to 2, then 1 and 3 compete: 3 first, then 1.
    @(negedge clk); req = 4'b0010; #1;
    check_val("t3_gnt_first", gnt, 4'b0010);
    @(negedge clk); req = 4'b1010; #1;
    check_val("t3_gnt_rot", gnt, 4'b1000);
    @(negedge clk); req = 4'b0010; #1;
    check_val("t3_gnt_wrap", gnt, 4'b0010);
    @(negedge clk); req = '0; #1;
    check_val("t3_rsp0_id", rsp_id, 1);
    check_val("t3_rsp0_data", rsp_data, 14);
    @(negedge clk); #1;
    check_val("t3_rsp1_id", rsp_id, 3);
    check_val("t3_rsp1_data", rsp_data, 38);
    @(negedge clk); #1;
    check_val("t3_rsp2_valid", rsp_valid, 1);
    check_val("t3_rsp2_id", rsp_id, 1);
    @(negedge clk); #1;
    check_val("t3_idle", idle, 1);

    // Two ops in flight, then drain; drain drops mid-way but must not abort.
    @(negedge clk); req = 4'b0001; #1;
    check_val("t4_gnt0", gnt, 4'b0001);
    @(negedge clk); req = 4'b0010; #1;
    check_val("t4_gnt1", gnt, 4'b0010);
    @(negedge clk); req = 4'b1111; drain = 1'b1; #1;
    check_val("t4_blk0", gnt, 0);
    check_val("t4_mac_en", mac_en, 1);
    n_dd = int'(drain_done);
    @(negedge clk); drain = 1'b0; #1;
    check_val("t4_blk1", gnt, 0);
    check_val("t4_rsp0_valid", rsp_valid, 1);
    check_val("t4_rsp0_id", rsp_id, 0);
    check_val("t4_rsp0_data", rsp_data, 2);
    n_dd += int'(drain_done);
    @(negedge clk); #1;
    check_val("t4_blk2", gnt, 0);
    check_val("t4_rsp1_id", rsp_id, 1);
    check_val("t4_rsp1_data", rsp_data, 14);
    n_dd += int'(drain_done);
    @(negedge clk); req = '0; #1;
    check_val("t4_drain_done", drain_done, 1);
    check_val("t4_idle", idle, 1);
    n_dd += int'(drain_done);
    repeat (3) begin
      @(negedge clk); #1;
      n_dd += int'(drain_done);
    end
    check_val("t4_dd_once", n_dd, 1);
    @(negedge clk); req = 4'b0100; #1;
    check_val("t4_resume", gnt, 4'b0100);
    @(negedge clk); req = '0;
    repeat (4) @(negedge clk);

    // Drain on an empty pipeline acknowledges once, on the next cycle.
    @(negedge clk); drain = 1'b1; #1;
    check_val("t4b_dd_pre", drain_done, 0);
    @(negedge clk); #1;
    check_val("t4b_dd", drain_done, 1);
    @(negedge clk); #1;
    check_val("t4b_dd_once", drain_done, 0);
    drain = 1'b0;

    // Reset with three ops in flight: nothing may come back.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); req = 4'b1111; #1;
      check_val("t5_issue", mac_en, 1);
    end
    @(negedge clk); req = '0; rst = 1'b1; #1;
    check_val("t5_gnt", gnt, 0);
    check_val("t5_mac_en", mac_en, 0);
    check_val("t5_rsp_valid", rsp_valid, 0);
    check_val("t5_idle", idle, 1);
    check_val("t5_drain_done", drain_done, 0);
    check_val("t5_mac_cin", mac_cin, 0);
    @(negedge clk); rst = 1'b0;
    n_rsp = 0;
    repeat (6) begin
      @(negedge clk); #1;
      n_rsp += int'(rsp_valid);
    end
    check_val("t5_no_rsp", n_rsp, 0);

`ifdef MAC_RR_SCHEDULER_PERF_EN
    check_val("perf_grants_rst", perf_grants, 0);
    repeat (5) begin
      @(negedge clk); req = 4'b0001;
    end
    @(negedge clk); req = '0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); drain = 1'b1; req = 4'b0001; #1;
      check_val("perf_blk", gnt, 0);
    end
    @(negedge clk); drain = 1'b0; req = '0; #1;
    check_val("perf_grants", perf_grants, 5);
    check_val("perf_stalls", perf_stalls, 4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
